// File: rtl/bpred_ctrl_pkg.sv
// Shared definitions for the branch-predictor table port controller.
//   bpred_state_e : controller state (sweep in progress or idle arbitration)
//   upd_entry_t   : default queued-update record {index, data}
//   DefInitValue  : default sweep fill value (weakly not taken)
package bpred_ctrl_pkg;

  typedef enum logic [0:0] {
    StSweep,
    StIdle
  } bpred_state_e;

  localparam int unsigned DefIndexBits = 10;
  localparam int unsigned DefDataBits  = 2;

  localparam logic [DefDataBits-1:0] DefInitValue = 2'b01;

  typedef struct packed {
    logic [DefIndexBits-1:0] idx;
    logic [DefDataBits-1:0]  data;
  } upd_entry_t;

endpackage

// File: rtl/bpupdq.sv
// Two-entry coalescing update FIFO for the predictor table controller.
//   clk_i        : core clock
//   flush_i      : empty the queue at the next edge (wins over push)
//   push_i       : offer push_entry_i; merges into the tail if the index matches
//   push_entry_i : {idx, data} of the incoming update
//   pop_i        : drop the head (ignored when empty)
//   head_o       : oldest entry
//   full_o       : two entries held
//   empty_o      : no entries held
module bpupdq
  import bpred_ctrl_pkg::*;
#(
  parameter type entry_t = upd_entry_t
) (
  input  logic   clk_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t push_entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  entry_t     slot_q [2];
  entry_t     slot_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       tail_sel;

  always_comb begin
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    tail_sel = 1'b0;
    if (pop_i && (cnt_q != 2'd0)) begin
      slot_d[0] = slot_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    // The tail is judged against the post-pop contents.
    tail_sel = cnt_d[1];
    if (push_i) begin
      if ((cnt_d != 2'd0) && (slot_d[tail_sel].idx == push_entry_i.idx)) begin
        slot_d[tail_sel].data = push_entry_i.data;
      end else if (cnt_d != 2'd2) begin
        slot_d[cnt_d[0]] = push_entry_i;
        cnt_d            = cnt_d + 2'd1;
      end
    end
    if (flush_i) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    slot_q <= slot_d;
    cnt_q  <= cnt_d;
  end

  assign head_o  = slot_q[0];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/bpred_table_ctrl.sv
// Port controller for a single-ported branch-predictor table.
// Shares the SRAM port among prediction reads, queued update writes and a
// full-table initialization sweep; at most one SRAM operation per cycle.
//   clk, reset               : clock, synchronous active-high reset
//   StallF, ReadIndexF       : prediction read request (needed when StallF=0)
//   SweepReq                 : restart table initialization
//   UpdateEnM/IndexM/DataM   : resolved-branch table update
//   TableEn/We/Adr/WData     : SRAM port
//   PredValidF               : SRAM read data this cycle is last cycle's read
//   Busy, SweepDone          : sweep in progress, last sweep write pulse
module bpred_table_ctrl
  import bpred_ctrl_pkg::*;
#(
  parameter int unsigned          INDEX_BITS = DefIndexBits,
  parameter int unsigned          DATA_BITS  = DefDataBits,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = DATA_BITS'(DefInitValue)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallF,
  input  logic [INDEX_BITS-1:0] ReadIndexF,
  input  logic                  SweepReq,
  input  logic                  UpdateEnM,
  input  logic [INDEX_BITS-1:0] UpdateIndexM,
  input  logic [DATA_BITS-1:0]  UpdateDataM,
  output logic                  TableEn,
  output logic                  TableWe,
  output logic [INDEX_BITS-1:0] TableAdr,
  output logic [DATA_BITS-1:0]  TableWData,
  output logic                  PredValidF,
  output logic                  Busy,
  output logic                  SweepDone
);

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic [DATA_BITS-1:0]  data;
  } entry_t;

  localparam logic [INDEX_BITS-1:0] LastIdx = '1;

  bpred_state_e          state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic                  pred_valid_q;
  logic                  rd_issue;

  entry_t head, upd_entry;
  logic   q_full, q_empty, q_push, q_pop, q_flush;

  assign upd_entry = '{idx: UpdateIndexM, data: UpdateDataM};

  always_comb begin
    TableEn     = 1'b0;
    TableWe     = 1'b0;
    TableAdr    = ReadIndexF;
    TableWData  = head.data;
    q_pop       = 1'b0;
    rd_issue    = 1'b0;
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (!reset) begin
      case (state_q)
        StSweep: begin
          TableEn    = 1'b1;
          TableWe    = 1'b1;
          TableAdr   = sweep_idx_q;
          TableWData = INIT_VALUE;
          if (SweepReq) begin
            sweep_idx_d = '0;
          end else begin
            // Wraps to zero on the last write, leaving the index ready for the next sweep.
            sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
            if (sweep_idx_q == LastIdx) begin
              state_d = StIdle;
            end
          end
        end
        StIdle: begin
          if (q_full || (!q_empty && StallF)) begin
            TableEn    = 1'b1;
            TableWe    = 1'b1;
            TableAdr   = head.idx;
            TableWData = head.data;
            q_pop      = 1'b1;
          end else if (!StallF) begin
            TableEn  = 1'b1;
            rd_issue = 1'b1;
          end
          if (SweepReq) begin
            state_d     = StSweep;
            sweep_idx_d = '0;
          end
        end
        default: begin
          state_d     = StSweep;
          sweep_idx_d = '0;
        end
      endcase
    end
  end

  // Updates only enter the queue while idle; a sweep or reset discards them.
  assign q_push  = UpdateEnM && (state_q == StIdle) && !reset;
  assign q_flush = reset || (state_q == StSweep) || SweepReq;

  bpupdq #(
    .entry_t(entry_t)
  ) u_updq (
    .clk_i       (clk),
    .flush_i     (q_flush),
    .push_i      (q_push),
    .push_entry_i(upd_entry),
    .pop_i       (q_pop),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StSweep;
      sweep_idx_q  <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      pred_valid_q <= rd_issue;
    end
  end

  assign PredValidF = pred_valid_q;
  assign Busy       = reset || (state_q == StSweep);
  // A restart requested on the final write takes precedence over completion.
  assign SweepDone  = !reset && (state_q == StSweep) && (sweep_idx_q == LastIdx) && !SweepReq;

endmodule

// File: tb/tb_bpred_table_ctrl.sv
module tb_bpred_table_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       StallF = 1'b0;
  logic [3:0] ReadIndexF = '0;
  logic       SweepReq = 1'b0;
  logic       UpdateEnM = 1'b0;
  logic [3:0] UpdateIndexM = '0;
  logic [1:0] UpdateDataM = '0;
  logic       TableEn, TableWe, PredValidF, Busy, SweepDone;
  logic [3:0] TableAdr;
  logic [1:0] TableWData;

  bpred_table_ctrl #(
    .INDEX_BITS(4),
    .DATA_BITS (2),
    .INIT_VALUE(2'b01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .ReadIndexF  (ReadIndexF),
    .SweepReq    (SweepReq),
    .UpdateEnM   (UpdateEnM),
    .UpdateIndexM(UpdateIndexM),
    .UpdateDataM (UpdateDataM),
    .TableEn     (TableEn),
    .TableWe     (TableWe),
    .TableAdr    (TableAdr),
    .TableWData  (TableWData),
    .PredValidF  (PredValidF),
    .Busy        (Busy),
    .SweepDone   (SweepDone)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: table owner, sweep position, pending-update list.
  typedef struct {
    logic [3:0] idx;
    logic [1:0] data;
  } ent_t;
  ent_t mq[$];
  bit   m_busy = 1'b1;
  int   m_idx = 0;
  bit   m_pv = 1'b0;

  logic c_en, c_we, c_pv, c_busy, c_done;
  logic [3:0] c_adr;
  logic [1:0] c_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic [3:0] ri, input logic ue,
                       input logic [3:0] ui, input logic [1:0] ud, input logic sr);
    logic e_en, e_we, e_busy, e_done, rd;
    logic [3:0] e_adr;
    logic [1:0] e_wd;
    @(negedge clk);
    reset = rst; StallF = st; ReadIndexF = ri; UpdateEnM = ue;
    UpdateIndexM = ui; UpdateDataM = ud; SweepReq = sr;
    #1;
    c_en = TableEn; c_we = TableWe; c_adr = TableAdr; c_wd = TableWData;
    c_pv = PredValidF; c_busy = Busy; c_done = SweepDone;
    e_en = 0; e_we = 0; e_adr = 0; e_wd = 0; e_busy = 0; e_done = 0; rd = 0;
    if (rst) begin
      e_busy = 1;
    end else if (m_busy) begin
      e_en = 1; e_we = 1; e_adr = 4'(m_idx); e_wd = 2'b01; e_busy = 1;
      e_done = (m_idx == 15) && !sr;
    end else if (mq.size() == 2 || (mq.size() > 0 && st)) begin
      e_en = 1; e_we = 1; e_adr = mq[0].idx; e_wd = mq[0].data;
    end else if (!st) begin
      e_en = 1; e_adr = ri; rd = 1;
    end
    chk("model_en", 32'(c_en), 32'(e_en));
    if (e_en) begin
      chk("model_we", 32'(c_we), 32'(e_we));
      chk("model_adr", 32'(c_adr), 32'(e_adr));
    end
    if (e_we) chk("model_wdata", 32'(c_wd), 32'(e_wd));
    chk("model_busy", 32'(c_busy), 32'(e_busy));
    chk("model_done", 32'(c_done), 32'(e_done));
    chk("model_pv", 32'(c_pv), 32'(m_pv));
    if (rst) begin
      m_busy = 1; m_idx = 0; mq.delete(); m_pv = 0;
    end else if (m_busy) begin
      m_pv = 0;
      if (sr) m_idx = 0;
      else if (m_idx == 15) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end else begin
      if (e_we) void'(mq.pop_front());
      if (ue) begin
        if (mq.size() > 0 && mq[mq.size()-1].idx == ui) mq[mq.size()-1].data = ud;
        else mq.push_back('{idx: ui, data: ud});
      end
      if (sr) begin m_busy = 1; m_idx = 0; mq.delete(); end
      m_pv = rd;
    end
  endtask

  typedef struct {
    logic       st;
    logic [3:0] ri;
    logic       ue;
    logic [3:0] ui;
    logic [1:0] ud;
    logic       sr;
    logic       en;
    logic       we;
    logic [3:0] adr;
    logic [1:0] wd;
    logic       pv;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int dones;
    //          st ri ue ui  ud sr  en we adr wd pv
    vecs[0]  = '{0, 5, 0, 0,  0, 0, 1, 0, 5,  0, 0};
    vecs[1]  = '{0, 6, 1, 3,  3, 0, 1, 0, 6,  0, 1};
    vecs[2]  = '{0, 7, 1, 7,  0, 0, 1, 0, 7,  0, 1};
    vecs[3]  = '{0, 8, 1, 12, 2, 0, 1, 1, 3,  3, 1};
    vecs[4]  = '{0, 8, 0, 0,  0, 0, 1, 1, 7,  0, 0};
    vecs[5]  = '{0, 9, 0, 0,  0, 0, 1, 0, 9,  0, 0};
    vecs[6]  = '{1, 0, 0, 0,  0, 0, 1, 1, 12, 2, 1};
    vecs[7]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vecs[8]  = '{0, 1, 1, 9,  2, 0, 1, 0, 1,  0, 0};
    vecs[9]  = '{0, 2, 1, 9,  3, 0, 1, 0, 2,  0, 1};
    vecs[10] = '{1, 0, 0, 0,  0, 0, 1, 1, 9,  3, 1};
    vecs[11] = '{1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vecs[12] = '{0, 0, 1, 4,  1, 0, 1, 0, 0,  0, 0};
    vecs[13] = '{1, 0, 1, 4,  2, 0, 1, 1, 4,  1, 1};
    vecs[14] = '{1, 0, 0, 0,  0, 0, 1, 1, 4,  2, 0};
    vecs[15] = '{1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vecs[16] = '{0, 3, 1, 1,  1, 0, 1, 0, 3,  0, 0};
    vecs[17] = '{0, 3, 1, 2,  2, 0, 1, 0, 3,  0, 1};
    vecs[18] = '{0, 3, 1, 5,  3, 1, 1, 1, 1,  1, 1};

    repeat (2) @(posedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_en", 32'(c_en), 32'd0);
    chk("reset_busy", 32'(c_busy), 32'd1);

    // Reset release sweep.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 4'(i), 1, 4'(i), 2'b11, 0);
      chk("init_adr", 32'(c_adr), 32'(i));
      chk("init_we", 32'(c_we), 32'd1);
      chk("init_wdata", 32'(c_wd), 32'd1);
      chk("init_done", 32'(c_done), 32'(i == 15));
    end
    cycle(0, 0, 2, 0, 0, 0, 0);
    chk("first_read_en", 32'(c_en), 32'd1);
    chk("first_read_we", 32'(c_we), 32'd0);
    chk("first_read_adr", 32'(c_adr), 32'd2);
    chk("first_read_busy", 32'(c_busy), 32'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("first_read_pv", 32'(c_pv), 32'd1);
    chk("idle_stall_en", 32'(c_en), 32'd0);

    // Vector table: reads, forced drain, coalesce, pop-then-push, sweep with drain.
    for (int v = 0; v < 19; v++) begin
      cycle(0, vecs[v].st, vecs[v].ri, vecs[v].ue, vecs[v].ui, vecs[v].ud, vecs[v].sr);
      chk($sformatf("vec%0d_en", v), 32'(c_en), 32'(vecs[v].en));
      if (vecs[v].en) begin
        chk($sformatf("vec%0d_we", v), 32'(c_we), 32'(vecs[v].we));
        chk($sformatf("vec%0d_adr", v), 32'(c_adr), 32'(vecs[v].adr));
      end
      if (vecs[v].we) chk($sformatf("vec%0d_wdata", v), 32'(c_wd), 32'(vecs[v].wd));
      chk($sformatf("vec%0d_pv", v), 32'(c_pv), 32'(vecs[v].pv));
    end

    // Sweep triggered alongside the drain: 16 writes, updates dropped.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1, 4'(i), 2'b10, 0);
      chk("drain_sweep_adr", 32'(c_adr), 32'(i));
      chk("drain_sweep_done", 32'(c_done), 32'(i == 15));
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("queue_flushed_en", 32'(c_en), 32'd0);
    chk("queue_flushed_busy", 32'(c_busy), 32'd0);

    // SweepReq at index 10 restarts from zero; exactly one done pulse.
    cycle(0, 1, 0, 0, 0, 0, 1);
    dones = 0;
    for (int i = 0; i <= 10; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 4'(i) == 4'd10);
      chk("restart_pre_adr", 32'(c_adr), 32'(i));
      if (c_done) dones++;
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("restart_adr", 32'(c_adr), 32'(i));
      chk("restart_busy", 32'(c_busy), 32'd1);
      if (c_done) dones++;
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("restart_done_count", 32'(dones), 32'd1);
    chk("restart_idle_busy", 32'(c_busy), 32'd0);

    // Reset at sweep index 6.
    cycle(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_adr", 32'(c_adr), 32'd5);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("midreset_en", 32'(c_en), 32'd0);
      chk("midreset_pv", 32'(c_pv), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("post_reset_adr", 32'(c_adr), 32'(i));
      chk("post_reset_pv", 32'(c_pv), 32'd0);
      chk("post_reset_done", 32'(c_done), 32'(i == 15));
    end

    // Randomized traffic against the model; small index range to provoke coalescing.
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
